mem_port_arbiter: RTL and testbench

Arbiter and sequencer sharing one single-port unified memory between the instruction-fetch (IF) stage and the data-access (MEM) stage of the 5-stage pipeline. Grants the memory to one stage at a time, drives a request/ready handshake to the memory, and returns read data. Generates `stallIF` / `stallMEM` freeze signals, combined with the load-use hazard stall at pipeline level. Times out accesses whose ready never arrives.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch and data-access
// stages. One access is in flight at a time; ties between the two requesters
// are broken round-robin. Accesses whose ready never arrives are aborted after
// TIMEOUT wait cycles and flagged on the sticky busErr output.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  output logic              ifValid,
  // data side
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memWdata,
  output logic [DATA_W-1:0] memRdata,
  output logic              memDone,
  // pipeline freeze
  output logic              stallIF,
  output logic              stallMEM,
  // memory request / response
  output logic              ramReq,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata,
  input  logic              ramReady,
  // sticky timeout indication
  output logic              busErr
);

  // Wait counter is at least 4 bits wide and always able to hold TIMEOUT.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  // The access aborts in the wait cycle that brings the count up to TIMEOUT,
  // i.e. when the registered count already holds TIMEOUT-1.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              bus_err_q, bus_err_d;

  logic mem_pend;
  logic in_acc;
  logic timeout_hit;
  logic complete;
  logic grant_if;
  logic grant_mem;

  assign mem_pend    = memRead | memWrite;
  assign in_acc      = (state_q != IDLE);
  assign timeout_hit = in_acc & ~ramReady & (wait_q == WAIT_LAST);
  assign complete    = in_acc & (ramReady | timeout_hit);

  // Arbitration in IDLE: a lone requester wins, a tie goes to the stage not
  // granted last time.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state_q == IDLE) begin
      if (mem_pend && ifReq) begin
        if (last_gnt_q == GNT_IF) begin
          grant_mem = 1'b1;
        end else begin
          grant_if = 1'b1;
        end
      end else if (mem_pend) begin
        grant_mem = 1'b1;
      end else if (ifReq) begin
        grant_if = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: grant leaves IDLE, completion (real or forced) returns.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = MEM_ACC;
        end else if (grant_if) begin
          state_d = IF_ACC;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Access context next-state: latched on grant, wait count advanced while
  // the memory keeps the access waiting, error flag set on abort.
  always_comb begin
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    wait_d     = wait_q;
    bus_err_d  = bus_err_q;
    if (grant_mem) begin
      addr_d     = memAddr;
      wdata_d    = memWdata;
      we_d       = memWrite;
      wait_d     = '0;
      last_gnt_d = GNT_MEM;
    end else if (grant_if) begin
      // Fetches never write; the write-data register keeps its old value.
      addr_d     = ifAddr;
      we_d       = 1'b0;
      wait_d     = '0;
      last_gnt_d = GNT_IF;
    end else if (in_acc && !ramReady && !timeout_hit) begin
      wait_d = wait_q + 1'b1;
    end
    if (timeout_hit) begin
      bus_err_d = 1'b1;
    end
  end

  // Access context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= GNT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wait_q     <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wait_q     <= wait_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Outputs: memory request from state, completion and data passthrough from
  // the memory response, freeze signals from pending requests.
  always_comb begin
    ramReq   = in_acc;
    ramWe    = in_acc & we_q;
    ramAddr  = addr_q;
    ramWdata = wdata_q;

    ifValid  = (state_q == IF_ACC) & complete;
    memDone  = (state_q == MEM_ACC) & complete;

    // A forced completion returns zero rather than whatever the bus holds.
    ifData   = ((state_q == IF_ACC) && ramReady) ? ramRdata : '0;
    memRdata = ((state_q == MEM_ACC) && ramReady) ? ramRdata : '0;

    stallMEM = mem_pend & ~memDone;
    stallIF  = (ifReq & ~ifValid) | stallMEM;

    busErr   = bus_err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. The stimulus thread predicts, at the
// transaction level, the order of grants, the memory requests and the
// completions; a memory-responder process checks the request side and a
// monitor process checks every completion pulse against the scoreboard.
module tb_mem_port_arbiter;

  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifData;
  logic        ifValid;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memDone;
  logic        stallIF;
  logic        stallMEM;
  logic        ramReq;
  logic        ramWe;
  logic [31:0] ramAddr;
  logic [31:0] ramWdata;
  logic [31:0] ramRdata;
  logic        ramReady;
  logic        busErr;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ifReq   (ifReq),
    .ifAddr  (ifAddr),
    .ifData  (ifData),
    .ifValid (ifValid),
    .memRead (memRead),
    .memWrite(memWrite),
    .memAddr (memAddr),
    .memWdata(memWdata),
    .memRdata(memRdata),
    .memDone (memDone),
    .stallIF (stallIF),
    .stallMEM(stallMEM),
    .ramReq  (ramReq),
    .ramWe   (ramWe),
    .ramAddr (ramAddr),
    .ramWdata(ramWdata),
    .ramRdata(ramRdata),
    .ramReady(ramReady),
    .busErr  (busErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          lat;      // ACC cycle in which ready is given; > TO means never
  } ram_item_t;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] data;
    bit          tmo;
  } rsp_item_t;

  ram_item_t exp_ram_q[$];
  rsp_item_t exp_rsp_q[$];

  logic [31:0] ram_mem [16];   // memory contents seen by the responder
  logic [31:0] ref_mem [16];   // reference copy advanced in predicted order
  bit          model_last_mem; // last granted stage in the reference model

  logic [31:0] if_addr_l  [8];
  logic [31:0] mem_addr_l [8];
  logic [31:0] mem_wd_l   [8];
  bit          mem_we_l   [8];
  int          lat_l      [16];

  int checks;
  int errors;
  bit exp_bus_err;

  function automatic logic [3:0] widx(input logic [31:0] a);
    return a[5:2];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the grant sequence for n_if fetches and n_mem data accesses that
  // are all presented together, each stage re-requesting right after its own
  // completion until its quota is used up.
  task automatic prepare(input int n_if, input int n_mem);
    int        i_if;
    int        i_m;
    int        g;
    bit        pick_mem;
    ram_item_t ri;
    rsp_item_t pi;
    i_if = 0;
    i_m  = 0;
    g    = 0;
    while (i_if < n_if || i_m < n_mem) begin
      if (i_if < n_if && i_m < n_mem) pick_mem = !model_last_mem;
      else                            pick_mem = (i_m < n_mem);
      ri.is_mem = pick_mem;
      ri.lat    = lat_l[g];
      if (pick_mem) begin
        ri.addr  = mem_addr_l[i_m];
        ri.we    = mem_we_l[i_m];
        ri.wdata = mem_wd_l[i_m];
        i_m++;
      end else begin
        ri.addr  = if_addr_l[i_if];
        ri.we    = 1'b0;
        ri.wdata = 32'h0;
        i_if++;
      end
      pi.is_mem = pick_mem;
      pi.we     = ri.we;
      pi.tmo    = (ri.lat > TO);
      pi.data   = pi.tmo ? 32'h0 : ref_mem[widx(ri.addr)];
      if (ri.we && !pi.tmo) ref_mem[widx(ri.addr)] = ri.wdata;
      model_last_mem = pick_mem;
      exp_ram_q.push_back(ri);
      exp_rsp_q.push_back(pi);
      g++;
    end
  endtask

  task automatic set_inputs(input int if_left, input int ii, input int mem_left, input int mi);
    ifReq    = (if_left > 0);
    ifAddr   = (if_left > 0) ? if_addr_l[ii] : 32'h0;
    memRead  = (mem_left > 0) && !mem_we_l[mi];
    memWrite = (mem_left > 0) && mem_we_l[mi];
    memAddr  = (mem_left > 0) ? mem_addr_l[mi] : 32'h0;
    memWdata = (mem_left > 0) ? mem_wd_l[mi] : 32'h0;
  endtask

  // Requester agents: hold each request until its completion pulse, then move
  // on to the next one at the edge that ends the completion cycle.
  task automatic drive(input int n_if, input int n_mem, input bit from_reset, output bit ok);
    int if_left;
    int mem_left;
    int ii;
    int mi;
    int cyc;
    bit fi;
    bit fm;
    if_left  = n_if;
    mem_left = n_mem;
    ii       = 0;
    mi       = 0;
    cyc      = 0;
    ok       = 1'b1;
    if (!from_reset) begin
      @(posedge clk);
      #1;
    end
    set_inputs(if_left, ii, mem_left, mi);
    if (from_reset) begin
      @(negedge clk);
      check("rst_ramReq", {31'b0, ramReq}, 32'h0);
      check("rst_ramWe", {31'b0, ramWe}, 32'h0);
      check("rst_ramAddr", ramAddr, 32'h0);
      check("rst_busErr", {31'b0, busErr}, 32'h0);
      check("rst_stallIF", {31'b0, stallIF}, {31'b0, (n_if > 0) || (n_mem > 0)});
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    while (if_left > 0 || mem_left > 0) begin
      @(negedge clk);
      fi = ifValid;
      fm = memDone;
      @(posedge clk);
      #1;
      if (fi && if_left > 0) begin
        if_left--;
        ii++;
      end
      if (fm && mem_left > 0) begin
        mem_left--;
        mi++;
      end
      set_inputs(if_left, ii, mem_left, mi);
      cyc++;
      if (cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL drive_budget: %0d fetches and %0d data accesses still outstanding, expected 0",
                 if_left, mem_left);
        ok = 1'b0;
        break;
      end
    end
    ifReq    = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return TO;
    if (r == 1) return TO + 1;
    return $urandom_range(1, 5);
  endfunction

  // Memory responder: checks the request side of every access and supplies
  // ready/data in the ACC cycle chosen for that access. Ready is also toggled
  // at random while no access is in progress.
  ram_item_t cur;
  bit        have_cur;
  int        r_cyc;
  int        limit;
  initial begin
    ramReady = 1'b0;
    ramRdata = 32'h0;
    have_cur = 1'b0;
    r_cyc    = 0;
  end
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      r_cyc    = 0;
      have_cur = 1'b0;
      ramReady = 1'b0;
      ramRdata = $urandom;
    end else if (ramReq) begin
      r_cyc++;
      if (r_cyc == 1) begin
        if (exp_ram_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ram_unexpected: got ramReq=1 addr 0x%08h, expected no request", ramAddr);
          have_cur = 1'b0;
        end else begin
          cur      = exp_ram_q.pop_front();
          have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        check("ram_addr", ramAddr, cur.addr);
        check("ram_we", {31'b0, ramWe}, {31'b0, cur.we});
        if (cur.we) check("ram_wdata", ramWdata, cur.wdata);
        limit = (cur.lat > TO) ? TO : cur.lat;
        check("ram_req_len_ok", {31'b0, (r_cyc <= limit)}, 32'h1);
        ramReady = (r_cyc == cur.lat);
      end else begin
        ramReady = 1'b0;
      end
      if (ramReady) begin
        ramRdata = ram_mem[widx(ramAddr)];
        if (ramWe) ram_mem[widx(ramAddr)] = ramWdata;
      end else begin
        ramRdata = $urandom;
      end
    end else begin
      r_cyc    = 0;
      have_cur = 1'b0;
      ramReady = ($urandom_range(0, 3) == 0);
      ramRdata = $urandom;
    end
  end

  // Monitor: freeze signals every cycle, completion pulses against the
  // scoreboard, sticky error flag against its expected history.
  rsp_item_t got;
  logic      exp_smem;
  logic      exp_sif;
  always @(negedge clk) begin
    exp_smem = (memRead | memWrite) & ~memDone;
    exp_sif  = (ifReq & ~ifValid) | exp_smem;
    check("stallMEM", {31'b0, stallMEM}, {31'b0, exp_smem});
    check("stallIF", {31'b0, stallIF}, {31'b0, exp_sif});
    if (rst) begin
      exp_bus_err = 1'b0;
      check("rst_busErr_hold", {31'b0, busErr}, 32'h0);
      check("rst_no_pulse", {30'b0, ifValid, memDone}, 32'h0);
    end else begin
      check("busErr", {31'b0, busErr}, {31'b0, exp_bus_err});
      if (ifValid && memDone) begin
        checks++;
        errors++;
        $display("FAIL both_done: got ifValid=1 memDone=1, expected at most one");
      end else if (ifValid || memDone) begin
        if (exp_rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got ifValid=%0b memDone=%0b, expected no completion",
                   ifValid, memDone);
        end else begin
          got = exp_rsp_q.pop_front();
          check("done_is_mem", {31'b0, memDone}, {31'b0, got.is_mem});
          if (!got.we) begin
            if (got.is_mem) check("memRdata", memRdata, got.data);
            else            check("ifData", ifData, got.data);
          end
          if (got.tmo) exp_bus_err = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    model_last_mem = 1'b0;
  endtask

  bit ok;
  int nf;
  int nm;
  initial begin
    checks      = 0;
    errors      = 0;
    exp_bus_err = 1'b0;
    ok          = 1'b1;
    rst         = 1'b1;
    ifReq       = 1'b0;
    ifAddr      = 32'h0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memAddr     = 32'h0;
    memWdata    = 32'h0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[0]     = 32'h8C220004;
    ref_mem[0]     = 32'h8C220004;
    model_last_mem = 1'b0;

    // Fetch at 0x40 held through reset, ready three cycles after ramReq.
    if_addr_l[0] = 32'h40;
    lat_l[0]     = 4;
    prepare(1, 0);
    drive(1, 0, 1'b1, ok);

    // Fetch and load both held from reset: MEM, IF, MEM, IF.
    if (ok) begin
      do_reset();
      if_addr_l[0]  = 32'h44;
      if_addr_l[1]  = 32'h48;
      mem_addr_l[0] = 32'h100;
      mem_addr_l[1] = 32'h100;
      mem_we_l[0]   = 1'b0;
      mem_we_l[1]   = 1'b0;
      for (int i = 0; i < 4; i++) lat_l[i] = $urandom_range(1, 4);
      prepare(2, 2);
      drive(2, 2, 1'b1, ok);
    end

    // Store 0xDEADBEEF at 0x200, then load it back.
    if (ok) begin
      mem_addr_l[0] = 32'h200;
      mem_we_l[0]   = 1'b1;
      mem_wd_l[0]   = 32'hDEADBEEF;
      mem_addr_l[1] = 32'h200;
      mem_we_l[1]   = 1'b0;
      mem_wd_l[1]   = 32'h0;
      lat_l[0]      = 5;
      lat_l[1]      = 2;
      prepare(0, 2);
      drive(0, 2, 1'b0, ok);
    end

    // Fetch that never gets ready, then a normal fetch; then a load whose
    // ready arrives in the last permitted wait cycle.
    if (ok) begin
      if_addr_l[0] = 32'h80;
      if_addr_l[1] = 32'h84;
      lat_l[0]     = TO + 1;
      lat_l[1]     = 2;
      prepare(2, 0);
      drive(2, 0, 1'b0, ok);
    end
    if (ok) begin
      mem_addr_l[0] = 32'h10;
      mem_we_l[0]   = 1'b0;
      lat_l[0]      = TO;
      prepare(0, 1);
      drive(0, 1, 1'b0, ok);
    end

    // Reset two cycles into a load: request drops at once, no completion.
    if (ok) begin
      mem_addr_l[0] = 32'h100;
      mem_we_l[0]   = 1'b0;
      lat_l[0]      = TO + 1;
      prepare(0, 1);
      @(posedge clk);
      #1;
      memRead = 1'b1;
      memAddr = 32'h100;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_ramReq", {31'b0, ramReq}, 32'h0);
      check("midrst_ramWe", {31'b0, ramWe}, 32'h0);
      check("midrst_memDone", {31'b0, memDone}, 32'h0);
      exp_rsp_q.delete();
      model_last_mem = 1'b0;
      memRead        = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      // A tie right after reset must go to MEM.
      if_addr_l[0]  = 32'h20;
      mem_addr_l[0] = 32'h24;
      mem_we_l[0]   = 1'b0;
      lat_l[0]      = 1;
      lat_l[1]      = 3;
      prepare(1, 1);
      drive(1, 1, 1'b0, ok);
    end

    // Randomized mixes of fetches, loads and stores with random latencies.
    for (int s = 0; s < 40 && ok; s++) begin
      nf = $urandom_range(0, 3);
      nm = $urandom_range(0, 3);
      if (nf == 0 && nm == 0) nm = 1;
      for (int i = 0; i < 8; i++) begin
        if_addr_l[i]  = {$urandom_range(0, 255), 2'b00};
        mem_addr_l[i] = {$urandom_range(0, 255), 2'b00};
        mem_we_l[i]   = ($urandom_range(0, 1) == 1);
        mem_wd_l[i]   = $urandom;
      end
      for (int i = 0; i < 16; i++) lat_l[i] = rand_lat();
      prepare(nf, nm);
      drive(nf, nm, 1'b0, ok);
    end

    repeat (5) @(posedge clk);
    #1;
    check("ram_queue_drained", exp_ram_q.size(), 32'h0);
    check("rsp_queue_drained", exp_rsp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
